// File: rtl/pc_gen_if.sv
// Fetch-request / response bundle between the PC generator (master) and the fetch stage (slave).
// misalign exists only when PCGEN_MISALIGN_CHECK_EN is defined.
interface pc_gen_if;
  logic        stall;
  logic        data_ok;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        valid;
  logic [31:0] inst_addr;
  logic        resp_valid;
  logic        discard;
  logic        busy;
`ifdef PCGEN_MISALIGN_CHECK_EN
  logic        misalign;

  modport master (
    input  stall, data_ok, jump_flag, jump_addr,
    output valid, inst_addr, resp_valid, discard, busy, misalign
  );
  modport slave (
    output stall, data_ok, jump_flag, jump_addr,
    input  valid, inst_addr, resp_valid, discard, busy, misalign
  );
`else
  modport master (
    input  stall, data_ok, jump_flag, jump_addr,
    output valid, inst_addr, resp_valid, discard, busy
  );
  modport slave (
    output stall, data_ok, jump_flag, jump_addr,
    input  valid, inst_addr, resp_valid, discard, busy
  );
`endif
endinterface

// File: rtl/pc_gen_unit.sv
// Sequential PC generator with outstanding-fetch tracking and stale-response dropping after jumps.
// Optional PCGEN_MISALIGN_CHECK_EN adds a one-cycle misalign pulse after a misaligned jump target.
module pc_gen_unit #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          CNT_W           = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] stale_reg;
  logic [CNT_W-1:0] stale_next;
  logic             valid;
  logic             issue;
  logic             discard;
  logic             resp_valid;
  logic             consume;

  assign valid      = (state_reg == ISSUE) &&
                      (outstanding_reg < CNT_W'(MAX_OUTSTANDING)) && !bus.jump_flag;
  assign issue      = valid && !bus.stall;
  // Stale responses are always the oldest in flight, so they are matched first.
  assign discard    = bus.data_ok && (stale_reg != '0);
  assign resp_valid = bus.data_ok && (stale_reg == '0) && (outstanding_reg != '0);
  assign consume    = discard || resp_valid;

  always_comb begin
    outstanding_next = outstanding_reg;
    unique case ({issue, consume})
      2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
      2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
      default: outstanding_next = outstanding_reg;
    endcase
  end

  // On a jump every request still in flight after this cycle's response becomes stale.
  always_comb begin
    stale_next = stale_reg;
    if (bus.jump_flag)
      stale_next = outstanding_next;
    else if (discard)
      stale_next = stale_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      stale_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      stale_reg       <= stale_next;

      if (bus.jump_flag)
        pc_reg <= bus.jump_addr & ~32'h3;
      else if (issue)
        pc_reg <= pc_reg + 32'd4;

      if (bus.jump_flag) begin
        state_reg <= (stale_next != '0) ? FLUSH : ISSUE;
      end else begin
        unique case (state_reg)
          IDLE:    state_reg <= ISSUE;
          ISSUE:   state_reg <= ISSUE;
          FLUSH:   state_reg <= (stale_next == '0) ? ISSUE : FLUSH;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.valid      = valid;
  assign bus.inst_addr  = pc_reg;
  assign bus.resp_valid = resp_valid;
  assign bus.discard    = discard;
  assign bus.busy       = (outstanding_reg != '0);

`ifdef PCGEN_MISALIGN_CHECK_EN
  logic misalign_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      misalign_reg <= 1'b0;
    else
      misalign_reg <= bus.jump_flag && (bus.jump_addr[1:0] != 2'b00);
  end

  assign bus.misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Testbench for pc_gen_unit: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_pc_gen_unit;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          MAX_OUT  = 2;
  localparam logic        N = 1'b0;
  localparam logic        Y = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if bus ();

  pc_gen_unit #(
    .RESET_PC(RESET_PC),
    .MAX_OUTSTANDING(MAX_OUT),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        stall;
    logic        dok;
    logic        jf;
    logic [31:0] ja;
    logic        valid;
    logic [31:0] addr;
    logic        resp;
    logic        disc;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic d, input logic j, input logic [31:0] ja,
                              input logic v, input logic [31:0] a, input logic r,
                              input logic ds, input logic b);
    vec_t t;
    t.stall = s; t.dok = d; t.jf = j; t.ja = ja;
    t.valid = v; t.addr = a; t.resp = r; t.disc = ds; t.busy = b;
    return t;
  endfunction

  task automatic drive(input logic s, input logic d, input logic j, input logic [31:0] a);
    bus.stall     = s;
    bus.data_ok   = d;
    bus.jump_flag = j;
    bus.jump_addr = a;
  endtask

  task automatic check(input string tag, input logic v, input logic [31:0] a,
                       input logic r, input logic ds, input logic b);
    n_vec++;
    if (bus.valid !== v || bus.inst_addr !== a || bus.resp_valid !== r ||
        bus.discard !== ds || bus.busy !== b) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b addr=%h resp=%0b discard=%0b busy=%0b, expected valid=%0b addr=%h resp=%0b discard=%0b busy=%0b",
               tag, bus.valid, bus.inst_addr, bus.resp_valid, bus.discard, bus.busy, v, a, r, ds, b);
    end else begin
      $display("ok   %s: valid=%0b addr=%h resp=%0b discard=%0b busy=%0b",
               tag, bus.valid, bus.inst_addr, bus.resp_valid, bus.discard, bus.busy);
    end
  endtask

`ifdef PCGEN_MISALIGN_CHECK_EN
  task automatic check_mis(input string tag, input logic m);
    n_vec++;
    if (bus.misalign !== m) begin
      n_bad++;
      $display("FAIL %s misalign: got %0b, expected %0b", tag, bus.misalign, m);
    end else begin
      $display("ok   %s misalign=%0b", tag, bus.misalign);
    end
  endtask
`endif

  // Reference model: a queue of in-flight requests, each flagged stale or current.
  bit          stale_q[$];
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_mis;

  task automatic model_reset();
    stale_q.delete();
    m_pc      = RESET_PC;
    m_started = 1'b0;
    m_mis     = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic d, input logic j, input logic [31:0] a,
                            output logic v, output logic [31:0] ad, output logic r,
                            output logic ds, output logic b, output logic mis);
    bit has_stale;
    has_stale = 1'b0;
    foreach (stale_q[i]) if (stale_q[i]) has_stale = 1'b1;
    v   = m_started && !has_stale && (stale_q.size() < MAX_OUT) && !j;
    ad  = m_pc;
    b   = (stale_q.size() != 0);
    r   = 1'b0;
    ds  = 1'b0;
    mis = m_mis;
    if (d && stale_q.size() != 0) begin
      if (stale_q.pop_front()) ds = 1'b1;
      else                     r  = 1'b1;
    end
    if (j) begin
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      m_pc = {a[31:2], 2'b00};
    end else if (v && !s) begin
      stale_q.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    m_mis     = j && (a[1:0] != 2'b00);
    m_started = 1'b1;
  endtask

  // Asserts reset at a falling edge, checks reset outputs, releases two cycles later.
  task automatic do_reset();
    reset_n = 1'b0;
    drive(N, N, N, 32'h0);
    #1;
    check("reset", N, RESET_PC, N, N, N);
`ifdef PCGEN_MISALIGN_CHECK_EN
    check_mis("reset", N);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t        tbl[16];
    logic        e_v, e_r, e_ds, e_b, e_m;
    logic [31:0] e_a;
    logic        s, d, j;
    logic [31:0] a;

    //             stall dok jf  jump_addr      valid addr           resp disc busy
    tbl[0]  = mk(N, N, N, 32'h0,          N, 32'h8000_0000, N, N, N);
    tbl[1]  = mk(N, N, N, 32'h0,          Y, 32'h8000_0000, N, N, N);
    tbl[2]  = mk(N, N, N, 32'h0,          Y, 32'h8000_0004, N, N, Y);
    tbl[3]  = mk(N, N, N, 32'h0,          N, 32'h8000_0008, N, N, Y);
    tbl[4]  = mk(N, Y, N, 32'h0,          N, 32'h8000_0008, Y, N, Y);
    tbl[5]  = mk(N, N, N, 32'h0,          Y, 32'h8000_0008, N, N, Y);
    tbl[6]  = mk(N, N, Y, 32'h8000_1000,  N, 32'h8000_000C, N, N, Y);
    tbl[7]  = mk(N, Y, N, 32'h0,          N, 32'h8000_1000, N, Y, Y);
    tbl[8]  = mk(N, Y, N, 32'h0,          N, 32'h8000_1000, N, Y, Y);
    tbl[9]  = mk(N, N, N, 32'h0,          Y, 32'h8000_1000, N, N, N);
    tbl[10] = mk(N, Y, Y, 32'h8000_3000,  N, 32'h8000_1004, Y, N, Y);
    tbl[11] = mk(N, N, N, 32'h0,          Y, 32'h8000_3000, N, N, N);
    tbl[12] = mk(Y, Y, N, 32'h0,          Y, 32'h8000_3004, Y, N, Y);
    tbl[13] = mk(N, N, N, 32'h0,          Y, 32'h8000_3004, N, N, N);
    tbl[14] = mk(Y, Y, N, 32'h0,          Y, 32'h8000_3008, Y, N, Y);
    tbl[15] = mk(Y, Y, N, 32'h0,          Y, 32'h8000_3008, N, N, N);

    drive(N, N, N, 32'h0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stall, tbl[i].dok, tbl[i].jf, tbl[i].ja);
      #1;
      check($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].addr, tbl[i].resp, tbl[i].disc, tbl[i].busy);
      @(negedge clk);
    end

    // Idle jump to 0x8000_0010, then hold the request under stall for 5 cycles.
    drive(Y, N, Y, 32'h8000_0010);
    #1;
    check("stall_jump", N, 32'h8000_3008, N, N, N);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      drive(Y, N, N, 32'h0);
      #1;
      check($sformatf("stall%0d", k), Y, 32'h8000_0010, N, N, N);
      @(negedge clk);
    end
    drive(N, N, N, 32'h0);
    #1;
    check("unstall", Y, 32'h8000_0010, N, N, N);
    @(negedge clk);
    drive(Y, N, N, 32'h0);
    #1;
    check("after_stall", Y, 32'h8000_0014, N, N, Y);
    @(negedge clk);

    // Reset with a request still in flight, then a misaligned jump.
    do_reset();
    drive(Y, N, N, 32'h0);
    #1;
    check("mis_idle", N, RESET_PC, N, N, N);
    @(negedge clk);
    drive(Y, N, Y, 32'h8000_2002);
    #1;
    check("mis_jump", N, RESET_PC, N, N, N);
    @(negedge clk);
    drive(Y, N, N, 32'h0);
    #1;
    check("mis_target", Y, 32'h8000_2000, N, N, N);
`ifdef PCGEN_MISALIGN_CHECK_EN
    check_mis("mis_target", Y);
`endif
    @(negedge clk);
    drive(Y, N, N, 32'h0);
    #1;
    check("mis_after", Y, 32'h8000_2000, N, N, N);
`ifdef PCGEN_MISALIGN_CHECK_EN
    check_mis("mis_after", N);
`endif
    @(negedge clk);

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        model_reset();
      end
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 14) == 0);
      a = $urandom;
      drive(s, d, j, a);
      #1;
      model_step(s, d, j, a, e_v, e_a, e_r, e_ds, e_b, e_m);
      check($sformatf("rnd%0d", c), e_v, e_a, e_r, e_ds, e_b);
`ifdef PCGEN_MISALIGN_CHECK_EN
      check_mis($sformatf("rnd%0d", c), e_m);
`endif
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
